// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and data access (MA).
// MA has priority, IF starvation is bounded, stuck accesses time out, and redirected fetches are discarded.
module mem_port_arbiter #(
  parameter int MAX_MA_STREAK = 4,
  parameter int TIMEOUT       = 64,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_stall,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic [1:0]  ma_read,
  input  logic [1:0]  ma_write,
  input  logic [31:0] ma_addr,
  input  logic [31:0] ma_wdata,
  output logic        ma_stall,
  output logic        ma_done,
  output logic [31:0] ma_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  localparam int STRK_W = (MAX_MA_STREAK < 1) ? 1 : $clog2(MAX_MA_STREAK + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q;
  logic              ownerIf_q;
  logic              discard_q;
  logic [STRK_W-1:0] streakCnt_q;
  logic [STRK_W-1:0] streakCnt_d;
  logic [CNT_W-1:0]  timeoutCnt_q;
  logic              memReq_q;
  logic              memWe_q;
  logic [1:0]        memSize_q;
  logic [31:0]       memAddr_q;
  logic [31:0]       memWdata_q;
  logic [31:0]       ifRdata_q;
  logic [31:0]       maRdata_q;
  logic              ifDone_q;
  logic              maDone_q;
  logic              busErr_q;

  logic maValid;
  logic streakFull;
  logic grantMa;
  logic grantIf;
  logic timeoutHit;
  logic discardNow;

  assign maValid    = (ma_read != 2'b00) || (ma_write != 2'b00);
  assign streakFull = (streakCnt_q == STRK_W'(MAX_MA_STREAK));
  assign grantMa    = maValid && !(if_req && streakFull);
  assign grantIf    = if_req && !grantMa;
  assign timeoutHit = (TIMEOUT != 0) && (timeoutCnt_q == CNT_W'(TIMEOUT - 1));
  // A flush arriving on the completing edge itself must also drop the fetch.
  assign discardNow = ownerIf_q && (discard_q || if_flush);

  always_comb begin
    streakCnt_d = streakCnt_q;
    if (grantMa && if_req) begin
      streakCnt_d = streakFull ? streakCnt_q : streakCnt_q + STRK_W'(1);
    end else if (grantMa || grantIf) begin
      streakCnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ownerIf_q    <= 1'b0;
      discard_q    <= 1'b0;
      streakCnt_q  <= '0;
      timeoutCnt_q <= '0;
      memReq_q     <= 1'b0;
      memWe_q      <= 1'b0;
      memSize_q    <= 2'b00;
      memAddr_q    <= '0;
      memWdata_q   <= '0;
      ifRdata_q    <= '0;
      maRdata_q    <= '0;
      ifDone_q     <= 1'b0;
      maDone_q     <= 1'b0;
      busErr_q     <= 1'b0;
    end else begin
      ifDone_q <= 1'b0;
      maDone_q <= 1'b0;
      busErr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grantMa || grantIf) begin
            state_q      <= BUSY;
            memReq_q     <= 1'b1;
            ownerIf_q    <= grantIf;
            streakCnt_q  <= streakCnt_d;
            timeoutCnt_q <= '0;
            discard_q    <= 1'b0;
            if (grantIf) begin
              memWe_q   <= 1'b0;
              memSize_q <= 2'b11;
              memAddr_q <= if_addr;
            end else begin
              memWe_q    <= (ma_write != 2'b00);
              memSize_q  <= (ma_write != 2'b00) ? ma_write : ma_read;
              memAddr_q  <= ma_addr;
              memWdata_q <= ma_wdata;
            end
          end
        end
        BUSY: begin
          if (ownerIf_q && if_flush) begin
            discard_q <= 1'b1;
          end
          if (mem_ready || timeoutHit) begin
            memReq_q <= 1'b0;
            state_q  <= DONE;
            busErr_q <= !mem_ready && !discardNow;
            if (ownerIf_q) begin
              if (!discardNow) begin
                ifDone_q  <= 1'b1;
                ifRdata_q <= mem_ready ? mem_rdata : '0;
              end
            end else begin
              maDone_q <= 1'b1;
              if (!mem_ready) begin
                maRdata_q <= '0;
              end else if (!memWe_q) begin
                maRdata_q <= mem_rdata;
              end
            end
          end else if (TIMEOUT != 0) begin
            timeoutCnt_q <= timeoutCnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q   <= IDLE;
          discard_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_stall  = if_req & ~ifDone_q;
  assign ma_stall  = maValid & ~maDone_q;
  assign if_done   = ifDone_q;
  assign if_rdata  = ifRdata_q;
  assign ma_done   = maDone_q;
  assign ma_rdata  = maRdata_q;
  assign mem_req   = memReq_q;
  assign mem_we    = memWe_q;
  assign mem_size  = memSize_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign bus_err   = busErr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scoreboard of expected completions plus
// per-scenario tasks covering fetch, contention, starvation guard, stores, flush, timeout and reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_stall;
  logic        if_done;
  logic [31:0] if_rdata;
  logic [1:0]  ma_read = 2'b00;
  logic [1:0]  ma_write = 2'b00;
  logic [31:0] ma_addr = '0;
  logic [31:0] ma_wdata = '0;
  logic        ma_stall;
  logic        ma_done;
  logic [31:0] ma_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  int memLat   = 1;
  bit memNever = 1'b0;
  int busyCnt  = 0;

  typedef struct {
    bit          isIf;
    logic [31:0] rdata;
    bit          busErr;
  } exp_t;

  exp_t expQ[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MAX_MA_STREAK(4),
    .TIMEOUT(8),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_flush(if_flush),
    .if_stall(if_stall),
    .if_done(if_done),
    .if_rdata(if_rdata),
    .ma_read(ma_read),
    .ma_write(ma_write),
    .ma_addr(ma_addr),
    .ma_wdata(ma_wdata),
    .ma_stall(ma_stall),
    .ma_done(ma_done),
    .ma_rdata(ma_rdata),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_size(mem_size),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .bus_err(bus_err)
  );

  function automatic logic [31:0] memVal(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: ready in the memLat-th cycle of mem_req, garbage data otherwise.
  always @(negedge clk) begin
    if (mem_req) begin
      busyCnt   = busyCnt + 1;
      mem_ready = !memNever && (busyCnt >= memLat);
      mem_rdata = memVal(mem_addr);
    end else begin
      busyCnt   = 0;
      mem_ready = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
    end
  end

  task automatic waitDone(input int maxCyc, output bit ok);
    int waited;
    ok = 1'b0;
    waited = 0;
    while (!ok && waited < maxCyc) begin
      @(negedge clk);
      waited++;
      if (if_done || ma_done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, if_done, ma_done, bus_err} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, if_done, ma_done, bus_err});
    end
    checks++;
    if ({mem_size, mem_addr, mem_wdata} !== 66'b0) begin
      errors++;
      $display("[TB] FAIL reset_mem: got size %b addr %h wdata %h expected zeros", mem_size, mem_addr, mem_wdata);
    end
    checks++;
    if ({if_rdata, ma_rdata} !== 64'b0) begin
      errors++;
      $display("[TB] FAIL reset_rdata: got %h %h expected zeros", if_rdata, ma_rdata);
    end
    checks++;
    if ({if_stall, ma_stall} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_stall: got %b expected 00", {if_stall, ma_stall});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_no_req: got %b expected 0", mem_req);
    end
  endtask

  task automatic test_single_fetch();
    exp_t e;
    memLat  = 1;
    if_req  = 1'b1;
    if_addr = 32'h0000_0100;
    expQ.push_back('{isIf: 1'b1, rdata: 32'h0050_0093, busErr: 1'b0});
    #1;
    checks++;
    if (if_stall !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fetch_c0: got stall %b req %b expected 1 0", if_stall, mem_req);
    end
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_size, mem_addr} !== {1'b1, 1'b0, 2'b11, 32'h0000_0100}) begin
      errors++;
      $display("[TB] FAIL fetch_c1_bus: got req %b we %b size %b addr %h expected 1 0 11 00000100",
               mem_req, mem_we, mem_size, mem_addr);
    end
    checks++;
    if (if_done !== 1'b0 || if_stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fetch_c1_stall: got done %b stall %b expected 0 1", if_done, if_stall);
    end
    @(negedge clk);
    e = expQ.pop_front();
    checks++;
    if (if_done !== e.isIf || ma_done !== 1'b0 || bus_err !== e.busErr) begin
      errors++;
      $display("[TB] FAIL fetch_c2_done: got if %b ma %b err %b expected 1 0 0", if_done, ma_done, bus_err);
    end
    checks++;
    if (if_rdata !== e.rdata) begin
      errors++;
      $display("[TB] FAIL fetch_rdata: got %h expected %h", if_rdata, e.rdata);
    end
    checks++;
    if (if_stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fetch_c2_stall: got stall %b req %b expected 0 0", if_stall, mem_req);
    end
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fetch_pulse_width: got %b expected 0", if_done);
    end
  endtask

  task automatic test_contention();
    exp_t        e;
    logic [31:0] got;
    int          cyc;
    int          maCyc;
    int          ifCyc;
    memLat  = 1;
    if_req  = 1'b1;
    if_addr = 32'h0000_0200;
    ma_read = 2'b11;
    ma_addr = 32'h0000_2000;
    expQ.push_back('{isIf: 1'b0, rdata: memVal(32'h0000_2000), busErr: 1'b0});
    expQ.push_back('{isIf: 1'b1, rdata: memVal(32'h0000_0200), busErr: 1'b0});
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_size, mem_addr} !== {1'b1, 1'b0, 2'b11, 32'h0000_2000}) begin
      errors++;
      $display("[TB] FAIL contention_first_grant: got req %b we %b size %b addr %h expected 1 0 11 00002000",
               mem_req, mem_we, mem_size, mem_addr);
    end
    cyc = 1;
    maCyc = -1;
    ifCyc = -1;
    while (expQ.size() != 0 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (if_done || ma_done) begin
        e = expQ.pop_front();
        checks++;
        if (if_done !== e.isIf || ma_done !== !e.isIf) begin
          errors++;
          $display("[TB] FAIL contention_order: got if %b ma %b expected if %b", if_done, ma_done, e.isIf);
        end
        got = e.isIf ? if_rdata : ma_rdata;
        checks++;
        if (got !== e.rdata) begin
          errors++;
          $display("[TB] FAIL contention_rdata: got %h expected %h", got, e.rdata);
        end
        if (ma_done) begin
          maCyc = cyc;
          ma_read = 2'b00;
        end
        if (if_done) begin
          ifCyc = cyc;
          if_req = 1'b0;
        end
      end
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL contention_wait: got %0d pending expected 0", expQ.size());
      expQ.delete();
      ma_read = 2'b00;
      if_req = 1'b0;
    end
    checks++;
    if (ifCyc - maCyc != 3) begin
      errors++;
      $display("[TB] FAIL contention_spacing: got %0d expected 3", ifCyc - maCyc);
    end
  endtask

  task automatic test_starvation();
    bit grantQ[$];
    bit expIf;
    bit isIfGrant;
    bit prevReq;
    bit sawIfDone;
    int n;
    for (int i = 0; i < 6; i++) grantQ.push_back(i == 4);
    memLat  = 1;
    if_req  = 1'b1;
    if_addr = 32'h0000_0400;
    ma_read = 2'b11;
    ma_addr = 32'h0000_2000;
    prevReq = mem_req;
    sawIfDone = 1'b0;
    n = 0;
    while (grantQ.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
      if (mem_req && !prevReq) begin
        expIf = grantQ.pop_front();
        isIfGrant = (mem_addr == 32'h0000_0400);
        checks++;
        if (isIfGrant !== expIf) begin
          errors++;
          $display("[TB] FAIL starvation_grant: got if-grant %b expected %b (%0d left)", isIfGrant, expIf,
                   grantQ.size());
        end
        if (grantQ.size() == 0) ma_read = 2'b00;
      end
      if (if_done) begin
        sawIfDone = 1'b1;
        if_req = 1'b0;
      end
      prevReq = mem_req;
    end
    if (grantQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL starvation_wait: got %0d grants pending expected 0", grantQ.size());
      ma_read = 2'b00;
      if_req = 1'b0;
    end
    checks++;
    if (!sawIfDone) begin
      errors++;
      $display("[TB] FAIL starvation_if_done: got 0 expected 1");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_store();
    exp_t e;
    bit   ok;
    int   n;
    memLat   = 3;
    ma_write = 2'b01;
    ma_addr  = 32'h0000_0003;
    ma_wdata = 32'h0000_00AB;
    expQ.push_back('{isIf: 1'b0, rdata: memVal(32'h0000_2000), busErr: 1'b0});
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, mem_size, mem_addr, mem_wdata} !==
          {1'b1, 1'b1, 2'b01, 32'h0000_0003, 32'h0000_00AB}) begin
        errors++;
        $display("[TB] FAIL store_hold_c%0d: got req %b we %b size %b addr %h wdata %h expected 1 1 01 00000003 000000ab",
                 c, mem_req, mem_we, mem_size, mem_addr, mem_wdata);
      end
    end
    @(negedge clk);
    e = expQ.pop_front();
    checks++;
    if (ma_done !== 1'b1 || if_done !== 1'b0 || bus_err !== e.busErr || ma_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL store_done: got ma %b if %b err %b stall %b expected 1 0 0 0", ma_done, if_done, bus_err,
               ma_stall);
    end
    checks++;
    if (ma_rdata !== e.rdata) begin
      errors++;
      $display("[TB] FAIL store_rdata_kept: got %h expected %h", ma_rdata, e.rdata);
    end
    memLat   = 1;
    ma_read  = 2'b11;
    ma_write = 2'b10;
    ma_addr  = 32'h0000_0010;
    ma_wdata = 32'h0000_1234;
    expQ.push_back('{isIf: 1'b0, rdata: memVal(32'h0000_2000), busErr: 1'b0});
    n = 0;
    while (!mem_req && n < 6) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({mem_req, mem_we, mem_size, mem_wdata} !== {1'b1, 1'b1, 2'b10, 32'h0000_1234}) begin
      errors++;
      $display("[TB] FAIL rw_both_as_write: got req %b we %b size %b wdata %h expected 1 1 10 00001234",
               mem_req, mem_we, mem_size, mem_wdata);
    end
    waitDone(6, ok);
    e = expQ.pop_front();
    checks++;
    if (!ok || ma_done !== 1'b1 || ma_rdata !== e.rdata) begin
      errors++;
      $display("[TB] FAIL rw_both_done: got done %b rdata %h expected 1 %h", ma_done, ma_rdata, e.rdata);
    end
    ma_read  = 2'b00;
    ma_write = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_flush();
    exp_t        e;
    bit          ok;
    logic [31:0] prevIf;
    int          hiCnt;
    prevIf  = memVal(32'h0000_0400);
    memLat  = 5;
    if_req  = 1'b1;
    if_addr = 32'h0000_0800;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0800) begin
      errors++;
      $display("[TB] FAIL flush_grant: got req %b addr %h expected 1 00000800", mem_req, mem_addr);
    end
    @(negedge clk);
    if_flush = 1'b1;
    if_req   = 1'b0;
    hiCnt = 0;
    for (int c = 3; c <= 5; c++) begin
      @(negedge clk);
      if_flush = 1'b0;
      if (mem_req) hiCnt++;
    end
    checks++;
    if (hiCnt != 3) begin
      errors++;
      $display("[TB] FAIL flush_req_held: got %0d cycles expected 3", hiCnt);
    end
    for (int c = 6; c <= 7; c++) begin
      @(negedge clk);
      checks++;
      if (if_done !== 1'b0 || if_rdata !== prevIf || mem_req !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_suppress_c%0d: got done %b rdata %h req %b expected 0 %h 0", c, if_done, if_rdata,
                 mem_req, prevIf);
      end
    end
    memLat  = 1;
    if_req  = 1'b1;
    if_addr = 32'h0000_0900;
    expQ.push_back('{isIf: 1'b1, rdata: memVal(32'h0000_0900), busErr: 1'b0});
    waitDone(10, ok);
    e = expQ.pop_front();
    checks++;
    if (!ok || if_done !== e.isIf || if_rdata !== e.rdata) begin
      errors++;
      $display("[TB] FAIL flush_refetch: got done %b rdata %h expected 1 %h", if_done, if_rdata, e.rdata);
    end
    if_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    exp_t e;
    int   hiCnt;
    int   n;
    bit   ok;
    memNever = 1'b1;
    ma_read  = 2'b11;
    ma_addr  = 32'h0000_0040;
    expQ.push_back('{isIf: 1'b0, rdata: 32'h0, busErr: 1'b1});
    hiCnt = 0;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      @(negedge clk);
      n++;
      if (mem_req) hiCnt++;
      if (ma_done || if_done) ok = 1'b1;
    end
    e = expQ.pop_front();
    checks++;
    if (hiCnt != 8) begin
      errors++;
      $display("[TB] FAIL timeout_busy_cycles: got %0d expected 8", hiCnt);
    end
    checks++;
    if (!ok || ma_done !== 1'b1 || bus_err !== e.busErr || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_abort: got done %b err %b req %b expected 1 1 0", ma_done, bus_err, mem_req);
    end
    checks++;
    if (ma_rdata !== e.rdata) begin
      errors++;
      $display("[TB] FAIL timeout_rdata: got %h expected %h", ma_rdata, e.rdata);
    end
    ma_read = 2'b00;
    memNever = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_err_pulse: got %b expected 0", bus_err);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_busy();
    exp_t e;
    bit   ok;
    memNever = 1'b1;
    if_req   = 1'b1;
    if_addr  = 32'h0000_0C00;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_busy_pre: got req %b expected 1", mem_req);
    end
    reset  = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_size, mem_addr, mem_wdata, if_done, ma_done, bus_err, if_rdata, ma_rdata} !== 135'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy_outputs: got req %b addr %h ifr %h mar %h expected all zero", mem_req, mem_addr,
               if_rdata, ma_rdata);
    end
    reset    = 1'b0;
    memNever = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy_idle: got req %b expected 0", mem_req);
    end
    memLat  = 1;
    ma_read = 2'b10;
    ma_addr = 32'h0000_0044;
    expQ.push_back('{isIf: 1'b0, rdata: memVal(32'h0000_0044), busErr: 1'b0});
    waitDone(10, ok);
    e = expQ.pop_front();
    checks++;
    if (!ok || ma_done !== 1'b1 || ma_rdata !== e.rdata) begin
      errors++;
      $display("[TB] FAIL reset_busy_resume: got done %b rdata %h expected 1 %h", ma_done, ma_rdata, e.rdata);
    end
    ma_read = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no end by 100000 expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_starvation();
    test_store();
    test_flush();
    test_timeout();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external memory port between the IF stage (instruction fetch, read-only) and the MA stage (data load/store).
- Sits between the cpu core and the unified memory model.
- Sequences each access with a registered req/ready handshake and issues per-stage stall and done signals.
- Data requests have priority, with a bounded-starvation guarantee for fetch, a timeout, and fetch-discard on PC redirect.

Parameters:
- MAX_MA_STREAK, 4: maximum consecutive MA grants while if_req is pending before IF is forced.
- TIMEOUT, 64: BUSY cycles without mem_ready before abort; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter. Must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request (level), held until if_done
- if_addr  in  32  fetch address
- if_flush  in  1  PC redirect; discard any in-flight fetch
- if_stall  out  1  if_req & ~if_done (combinational)
- if_done  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  32  fetched instruction (registered)
- ma_read  in  2  00 none, 01 byte, 10 half, 11 word
- ma_write  in  2  same encoding as ma_read
- ma_addr  in  32  data address
- ma_wdata  in  32  store data
- ma_stall  out  1  (ma_read|ma_write != 0) & ~ma_done (combinational)
- ma_done  out  1  one-cycle pulse; ma_rdata valid for loads
- ma_rdata  out  32  load data (registered)
- mem_req  out  1  registered request to memory
- mem_we  out  1  1 = write
- mem_size  out  2  size code of the granted access
- mem_addr  out  32  latched address
- mem_wdata  out  32  latched store data
- mem_ready  in  1  memory completion; sampled only while mem_req=1
- mem_rdata  in  32  valid when mem_ready=1
- bus_err  out  1  one-cycle pulse with a done pulse on timeout

Behaviour:
- Reset (synchronous) forces:
  - state IDLE;
  - mem_req, mem_we, if_done, ma_done, bus_err = 0;
  - mem_size, mem_addr, mem_wdata, if_rdata, ma_rdata = 0;
  - streak and timeout counters = 0; discard flag = 0.
- Reset mid-access abandons the transaction; the memory side must tolerate mem_req dropping.
- States: IDLE, BUSY, DONE.
- IDLE arbitration:
  - A request is MA-valid if ma_read != 0 or ma_write != 0.
  - Both MA-valid and if_req: grant MA unless streak == MAX_MA_STREAK, in which case grant IF.
  - Only one requester: grant it. Neither: stay IDLE.
  - ma_read and ma_write both nonzero: treat as write, size from ma_write.
- Grant (IDLE->BUSY edge):
  - Latch mem_addr, mem_size, mem_we and mem_wdata (MA only); set mem_req = 1 and the owner bit.
  - IF grant: mem_we = 0, mem_size = 11.
- Streak counter:
  - MA grant with if_req high: streak++ (saturating at MAX_MA_STREAK).
  - IF grant, or MA grant with if_req low: streak = 0.
- BUSY:
  - mem_req held high with all mem_* outputs stable until mem_ready = 1.
  - On that edge: mem_req = 0, capture mem_rdata into the owner's rdata register (loads and fetches only; writes leave ma_rdata unchanged), go to DONE.
- DONE (exactly one cycle):
  - Owner's done pulses high. State returns to IDLE.
  - A new request is sampled no earlier than the following IDLE cycle.
- Latency: request seen in IDLE at cycle 0 -> mem_req high in cycle 1 -> mem_ready in cycle 1 earliest -> done in cycle 2.
  - Minimum 3 cycles per access. Back-to-back grants are spaced by at least 3 cycles.
- Timeout (TIMEOUT > 0):
  - Counter clears on grant and increments each BUSY cycle without mem_ready.
  - Reaching TIMEOUT: mem_req = 0, owner rdata = 0, go to DONE, bus_err pulses together with the owner's done.
- Flush:
  - if_flush while IF owns BUSY sets the discard flag.
  - The access still completes at memory, but if_done is suppressed in DONE and if_rdata is not updated. The flag clears in DONE.
  - if_flush in IDLE or DONE has no effect on the arbiter; the requester deasserts if_req itself.
  - if_flush coinciding with the DONE cycle does not suppress that pulse.
- mem_ready while mem_req = 0 is ignored.

Test Plan:
- Single fetch: if_req = 1, if_addr = 0x100, memory ready 1 cycle after req, mem_rdata = 0x00500093.
  - Expect mem_req in cycle 1, if_done in cycle 2, if_rdata = 0x00500093, if_stall low only in cycle 2.
- Contention: if_req and ma_read = 11 (addr 0x2000) asserted together.
  - Expect MA granted first, then IF.
  - ma_done precedes if_done by 3 cycles with a 1-cycle memory.
- Starvation guard: if_req held while MA re-requests continuously, MAX_MA_STREAK = 4.
  - Expect exactly 4 MA grants, then an IF grant, then MA resumes.
- Store: ma_write = 01, addr 0x3, wdata 0xAB.
  - Expect mem_we = 1, mem_size = 01, mem_wdata = 0xAB stable until ready.
  - Expect ma_done pulse; ma_rdata unchanged.
- Flush mid-fetch: memory latency 5 cycles, if_flush pulsed in cycle 2.
  - Expect mem_req held until ready, no if_done, if_rdata unchanged.
- Timeout and reset: TIMEOUT = 8, memory never ready.
  - Expect mem_req drop after 8 BUSY cycles, bus_err and ma_done together, ma_rdata = 0.
  - Separately, reset asserted while BUSY: next cycle IDLE, mem_req = 0, all outputs at reset values.
